// File: rtl/spi_arb_pkg.sv
// Shared types and default parameters for the SPI request arbiter.
// Imported by the interface, round-robin picker and arbiter top.
package spi_arb_pkg;
  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_TIMEOUT  = 1023;
  localparam int CNT_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT,
    HOLD
  } arb_state_e;
endpackage

// File: rtl/spi_req_arbiter_if.sv
// Requester-side bundle of the SPI arbiter: byte offers and responses.
// The slave modport is the arbiter; the master modport is the requesters.
interface spi_req_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [7:0]              rsp_data;
  logic [NUM_REQ-1:0]      rsp_err;

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request at or after
// the pointer, wrapping modulo N.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);
  logic [IW:0] w_sum;

  // Walk downward so the closest candidate to the pointer wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      if (i_req[w_sum[IW-1:0]]) begin
        o_idx   = w_sum[IW-1:0];
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI byte driver among NUM_REQ
// requesters, with per-slave chip select framing and a byte timeout.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  spi_req_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] o_cs_n,
  output logic               o_drv_start,
  output logic [7:0]         o_drv_data,
  input  logic               i_drv_done,
  input  logic [7:0]         i_drv_rdata
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_e         r_state, w_state_nxt;
  logic [IW-1:0]      r_grant, w_grant_nxt;
  logic [IW-1:0]      r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_cs_n, w_cs_n_nxt;
  logic               r_start, w_start_nxt;
  logic [7:0]         r_drv_data, w_drv_data_nxt;
  logic               r_last, w_last_nxt;
  logic               r_rsp_v, w_rsp_v_nxt;
  logic               r_rsp_e, w_rsp_e_nxt;
  logic [7:0]         r_rsp_data, w_rsp_data_nxt;

  logic [IW-1:0]      w_pick;
  logic               w_found;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_hs;

  spi_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  assign w_gnt_oh = NUM_REQ'(1) << r_grant;
  assign w_hs     = (r_state == ISSUE) &&
                    bus.req_valid[r_grant];

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_cs_n_nxt     = r_cs_n;
    w_start_nxt    = 1'b0;
    w_drv_data_nxt = r_drv_data;
    w_last_nxt     = r_last;
    w_rsp_v_nxt    = 1'b0;
    w_rsp_e_nxt    = 1'b0;
    w_rsp_data_nxt = r_rsp_data;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_cs_n_nxt  = ~(NUM_REQ'(1) << w_pick);
          w_cnt_nxt   = '0;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ISSUE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ISSUE: begin
        if (w_hs) begin
          w_drv_data_nxt = bus.req_data[r_grant];
          w_last_nxt     = bus.req_last[r_grant];
          w_start_nxt    = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (i_drv_done) begin
          w_rsp_v_nxt    = 1'b1;
          w_rsp_data_nxt = i_drv_rdata;
          w_cnt_nxt      = '0;
          w_state_nxt    = r_last ? HOLD : ISSUE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Abort the whole transaction, not just this byte.
          w_rsp_e_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
          w_cnt_nxt   = '0;
          w_cs_n_nxt  = '1;
          w_ptr_nxt   = (r_grant == IW'(NUM_REQ - 1)) ?
                        '0 : r_grant + 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_cs_n     <= '1;
      r_start    <= 1'b0;
      r_drv_data <= 8'h00;
      r_last     <= 1'b0;
      r_rsp_v    <= 1'b0;
      r_rsp_e    <= 1'b0;
      r_rsp_data <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_start    <= w_start_nxt;
      r_drv_data <= w_drv_data_nxt;
      r_last     <= w_last_nxt;
      r_rsp_v    <= w_rsp_v_nxt;
      r_rsp_e    <= w_rsp_e_nxt;
      r_rsp_data <= w_rsp_data_nxt;
    end
  end

  assign bus.req_ready = (r_state == ISSUE) ? w_gnt_oh : '0;
  assign bus.rsp_valid = r_rsp_v ? w_gnt_oh : '0;
  assign bus.rsp_err   = r_rsp_e ? w_gnt_oh : '0;
  assign bus.rsp_data  = r_rsp_data;
  assign o_cs_n        = r_cs_n;
  assign o_drv_start   = r_start;
  assign o_drv_data    = r_drv_data;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Randomized bench for spi_req_arbiter: requester queues and a byte
// driver stub, checked against a transaction-level arbitration model.
module tb_spi_req_arbiter;
  localparam int NR = 3;
  localparam int SU = 2;
  localparam int HD = 2;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] cs_n;
  logic          drv_start;
  logic [7:0]    drv_data;
  logic          drv_done;
  logic [7:0]    drv_rdata;

  spi_req_arbiter_if #(.NUM_REQ(NR)) bus ();

  spi_req_arbiter #(
    .NUM_REQ  (NR),
    .CS_SETUP (SU),
    .CS_HOLD  (HD),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_cs_n      (cs_n),
    .o_drv_start (drv_start),
    .o_drv_data  (drv_data),
    .i_drv_done  (drv_done),
    .i_drv_rdata (drv_rdata)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  int cyc = 0;

  // {noresp, last, data}
  logic [9:0] rq [NR][$];
  logic [9:0] hsq[$];
  int         gseq[$];

  bit act, was_idle, hs_pend, outst, in_hold;
  bit cur_last, cur_nr, rsp_pend, stall_en, stray_en;
  int g, ptr, t0, done_at, t_err, rel_at, fix_lat, fix_rd;
  int obs_st, obs_rv, obs_re;
  logic [7:0]    rsp_exp;
  logic [NR-1:0] prev_v;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(int i);
    return NR'(1) << i;
  endfunction

  function automatic int pick(logic [NR-1:0] v, int p);
    int j;
    for (int k = 0; k < NR; k++) begin
      j = (p + k) % NR;
      if (((v >> j) & NR'(1)) != '0) return j;
    end
    return 0;
  endfunction

  task automatic flush(int r);
    logic [9:0] b;
    while (rq[r].size() > 0) begin
      b = rq[r].pop_front();
      if (b[8]) break;
    end
  endtask

  function automatic int busy();
    int n;
    n = hsq.size() + int'(act) + int'(hs_pend) +
        int'(outst) + int'(rsp_pend);
    for (int i = 0; i < NR; i++) n += rq[i].size();
    return n;
  endfunction

  task automatic step();
    logic [NR-1:0] e_cs, e_rdy, e_rv, e_re, v;
    logic          e_st;
    logic [9:0]    b;
    @(negedge clk);
    cyc++;
    e_rv = '0;
    e_re = '0;
    e_st = 1'b0;
    e_cs = '1;
    if (rsp_pend) begin
      e_rv     = onehot(g);
      rsp_pend = 1'b0;
    end
    if (outst && cur_nr && cyc == t_err) begin
      e_re    = onehot(g);
      outst   = 1'b0;
      in_hold = 1'b1;
      rel_at  = cyc + HD;
      if (!cur_last) flush(g);
    end
    if (hs_pend) begin
      e_st     = 1'b1;
      hs_pend  = 1'b0;
      outst    = 1'b1;
      b        = hsq.pop_front();
      cur_last = b[8];
      cur_nr   = b[9];
      t_err    = cyc + TO;
      done_at  = cyc + ((fix_lat > 0) ? fix_lat :
                        int'($urandom_range(1, 16)));
      chk("drv_data", 32'(drv_data), 32'(b[7:0]));
    end
    if (was_idle) begin
      if (prev_v != '0) begin
        g        = pick(prev_v, ptr);
        act      = 1'b1;
        t0       = cyc;
        was_idle = 1'b0;
        gseq.push_back(g);
        e_cs     = ~onehot(g);
      end
    end else if (act && in_hold && cyc == rel_at) begin
      act      = 1'b0;
      in_hold  = 1'b0;
      ptr      = (g + 1) % NR;
      was_idle = 1'b1;
    end else begin
      e_cs = ~onehot(g);
    end
    e_rdy = (act && !in_hold && !outst && !hs_pend &&
             cyc >= t0 + SU) ? onehot(g) : '0;

    chk("cs_n", 32'(cs_n), 32'(e_cs));
    chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    chk("drv_start", 32'(drv_start), 32'(e_st));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    chk("rsp_err", 32'(bus.rsp_err), 32'(e_re));
    if (e_rv != '0)
      chk("rsp_data", 32'(bus.rsp_data), 32'(rsp_exp));
    obs_st += int'(drv_start);
    obs_rv += $countones(bus.rsp_valid);
    obs_re += $countones(bus.rsp_err);

    v = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_data[i] = 8'h00;
      bus.req_last[i] = 1'b0;
      if (rq[i].size() > 0) begin
        b = rq[i][0];
        bus.req_data[i] = b[7:0];
        bus.req_last[i] = b[8];
        if (!stall_en || $urandom_range(0, 3) != 0)
          v[i] = 1'b1;
      end
    end
    bus.req_valid = v;
    prev_v        = v;
    if ((v & e_rdy) != '0) begin
      b = rq[g].pop_front();
      hsq.push_back(b);
      hs_pend = 1'b1;
    end

    drv_done  = 1'b0;
    drv_rdata = 8'($urandom);
    if (outst && !cur_nr && cyc == done_at) begin
      drv_done = 1'b1;
      if (fix_rd >= 0) drv_rdata = 8'(fix_rd);
      rsp_exp  = drv_rdata;
      rsp_pend = 1'b1;
      outst    = 1'b0;
      if (cur_last) begin
        in_hold = 1'b1;
        rel_at  = cyc + 1 + HD;
      end
    end else if (stray_en && !outst &&
                 $urandom_range(0, 5) == 0) begin
      drv_done = 1'b1;
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (busy() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drained", 32'(busy()), 32'd0);
    repeat (3) step();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) rq[i].delete();
    hsq.delete();
    act      = 1'b0;
    hs_pend  = 1'b0;
    outst    = 1'b0;
    in_hold  = 1'b0;
    rsp_pend = 1'b0;
    was_idle = 1'b1;
    ptr      = 0;
    prev_v   = '0;
    bus.req_valid = '0;
    drv_done = 1'b0;
  endtask

  initial begin
    int r, len, n;
    logic [9:0] e;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    drv_done  = 1'b0;
    drv_rdata = 8'h00;
    stall_en  = 1'b0;
    stray_en  = 1'b0;
    fix_lat   = 0;
    fix_rd    = -1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'({NR{1'b1}}));
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_v", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_e", 32'(bus.rsp_err), 32'd0);
    chk("rst_start", 32'(drv_start), 32'd0);
    chk("rst_drv_data", 32'(drv_data), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b0;

    // contention: expect grants 0,1,2,0
    gseq.delete();
    rq[0].push_back({2'b01, 8'h10});
    rq[0].push_back({2'b01, 8'h11});
    rq[1].push_back({2'b01, 8'h20});
    rq[2].push_back({2'b01, 8'h30});
    drain(400);
    chk("cont_g0", 32'(gseq[0]), 32'd0);
    chk("cont_g1", 32'(gseq[1]), 32'd1);
    chk("cont_g2", 32'(gseq[2]), 32'd2);
    chk("cont_g3", 32'(gseq[3]), 32'd0);

    // single byte, 16-cycle driver, fixed reply
    fix_lat = 16;
    fix_rd  = 'h3C;
    gseq.delete();
    obs_rv  = 0;
    rq[0].push_back({2'b01, 8'hA5});
    drain(200);
    chk("single_gnt", 32'(gseq[0]), 32'd0);
    chk("single_rsp", 32'(obs_rv), 32'd1);
    fix_lat = 0;
    fix_rd  = -1;

    // three-byte transaction on requester 1
    obs_st = 0;
    obs_rv = 0;
    gseq.delete();
    rq[1].push_back({2'b00, 8'h01});
    rq[1].push_back({2'b00, 8'h02});
    rq[1].push_back({2'b01, 8'h03});
    drain(300);
    chk("multi_txn", 32'(gseq.size()), 32'd1);
    chk("multi_start", 32'(obs_st), 32'd3);
    chk("multi_rsp", 32'(obs_rv), 32'd3);

    // driver never answers
    obs_rv = 0;
    obs_re = 0;
    rq[2].push_back({2'b11, 8'h5A});
    drain(200);
    chk("to_err", 32'(obs_re), 32'd1);
    chk("to_rsp", 32'(obs_rv), 32'd0);

    // stray drv_done pulses while idle
    obs_rv   = 0;
    stray_en = 1'b1;
    repeat (30) step();
    chk("stray_rsp", 32'(obs_rv), 32'd0);

    // random traffic with stalls, stray dones, timeouts
    stall_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      r   = int'($urandom_range(0, NR - 1));
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) begin
        e[7:0] = 8'($urandom);
        e[8]   = (k == len - 1);
        e[9]   = ($urandom_range(0, 11) == 0);
        rq[r].push_back(e);
      end
    end
    drain(20000);

    // reset in the middle of a byte
    stall_en = 1'b0;
    stray_en = 1'b0;
    rq[0].push_back({2'b01, 8'h44});
    drain(200);
    rq[1].push_back({2'b11, 8'h77});
    n = 0;
    while (!outst && n < 50) begin
      step();
      n++;
    end
    chk("mid_wait", 32'(outst), 32'd1);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_cs_n", 32'(cs_n), 32'({NR{1'b1}}));
    chk("arst_start", 32'(drv_start), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    gseq.delete();
    obs_rv = 0;
    rq[0].push_back({2'b01, 8'h81});
    rq[1].push_back({2'b01, 8'h82});
    rq[2].push_back({2'b01, 8'h83});
    drain(400);
    chk("post_rst_gnt", 32'(gseq[0]), 32'd0);
    chk("post_rst_rsp", 32'(obs_rv), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end
endmodule
